// File: rtl/uart_bus_loader.sv
// Serial-driven bus initiator: decodes W/R/G/H commands from the UART receive stream, issues
// single word writes/reads on the memory bus and answers on the UART transmit path.
module uart_bus_loader #(
    parameter int unsigned TIMEOUT_CYCLES = 4800000,
    parameter int unsigned TO_WIDTH       = 23
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    output logic        mem_rstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rbusy,
    input  logic        mem_wbusy,
    output logic        cpu_hold,
    output logic        busy
);

    localparam logic [7:0] Ack = 8'h06;
    localparam logic [7:0] Nak = 8'h15;

    typedef enum logic [3:0] {
        StIdle, StAddr, StLen, StWdata, StWstore, StRreq, StRwait, StRsend, StResp
    } state_e;

    state_e               state_q, state_d;
    logic [31:0]          addr_q, addr_d;
    logic [15:0]          len_q, len_d;
    logic [31:0]          word_q, word_d;
    logic [1:0]           cnt_q, cnt_d;
    logic [7:0]           resp_q, resp_d;
    logic                 hold_q, hold_d;
    logic                 wr_q, wr_d;
    logic [TO_WIDTH-1:0]  to_q, to_d;
    logic                 to_hit;
    logic                 rx_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            addr_q  <= '0;
            len_q   <= '0;
            word_q  <= '0;
            cnt_q   <= '0;
            resp_q  <= '0;
            hold_q  <= 1'b1;
            wr_q    <= 1'b0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
            hold_q  <= hold_d;
            wr_q    <= wr_d;
            to_q    <= to_d;
        end
    end

    // Inter-byte silence counter; only meaningful while a command is still being received.
    assign rx_state = (state_q == StAddr) || (state_q == StLen) || (state_q == StWdata);
    assign to_hit   = (to_q == TO_WIDTH'(TIMEOUT_CYCLES - 1));

    always_comb begin
        to_d = '0;
        if (rx_state && !rx_valid && !to_hit) begin
            to_d = to_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        word_d  = word_q;
        cnt_d   = cnt_q;
        resp_d  = resp_q;
        hold_d  = hold_q;
        wr_d    = wr_q;

        case (state_q)
            StIdle: begin
                if (rx_valid) begin
                    cnt_d   = '0;
                    resp_d  = Ack;
                    state_d = StResp;
                    case (rx_data)
                        8'h57, 8'h52: begin
                            if (hold_q) begin
                                wr_d    = (rx_data == 8'h57);
                                state_d = StAddr;
                            end else begin
                                resp_d = Nak;
                            end
                        end
                        8'h47:   hold_d = 1'b0;
                        8'h48:   hold_d = 1'b1;
                        default: resp_d = Nak;
                    endcase
                end
            end
            StAddr: begin
                if (rx_valid) begin
                    addr_d = {rx_data, addr_q[31:8]};
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == 2'd3) begin
                        state_d = StLen;
                    end
                end else if (to_hit) begin
                    state_d = StIdle;
                end
            end
            StLen: begin
                if (rx_valid) begin
                    len_d = {rx_data, len_q[15:8]};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == 2'd1) begin
                        cnt_d = '0;
                        if (len_d == 16'd0) begin
                            resp_d  = Ack;
                            state_d = StResp;
                        end else begin
                            state_d = wr_q ? StWdata : StRreq;
                        end
                    end
                end else if (to_hit) begin
                    state_d = StIdle;
                end
            end
            StWdata: begin
                if (rx_valid) begin
                    word_d = {rx_data, word_q[31:8]};
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == 2'd3) begin
                        state_d = StWstore;
                    end
                end else if (to_hit) begin
                    state_d = StIdle;
                end
            end
            StWstore: begin
                if (!mem_wbusy) begin
                    addr_d  = addr_q + 32'd4;
                    len_d   = len_q - 16'd1;
                    state_d = StWdata;
                    if (len_q == 16'd1) begin
                        resp_d  = Ack;
                        state_d = StResp;
                    end
                end
            end
            StRreq: state_d = StRwait;
            StRwait: begin
                if (!mem_rbusy) begin
                    word_d  = mem_rdata;
                    cnt_d   = '0;
                    state_d = StRsend;
                end
            end
            StRsend: begin
                if (tx_ready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == 2'd3) begin
                        addr_d  = addr_q + 32'd4;
                        len_d   = len_q - 16'd1;
                        state_d = StRreq;
                        if (len_q == 16'd1) begin
                            resp_d  = Ack;
                            state_d = StResp;
                        end
                    end
                end
            end
            StResp: begin
                if (tx_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Low address bits are carried through increments but never reach the bus.
    always_comb begin
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        mem_wmask = 4'b0000;
        mem_rstrb = 1'b0;
        mem_addr  = {addr_q[31:2], 2'b00};
        mem_wdata = word_q;
        cpu_hold  = hold_q;
        busy      = (state_q != StIdle);
        case (state_q)
            StWstore: mem_wmask = mem_wbusy ? 4'b0000 : 4'b1111;
            StRreq:   mem_rstrb = 1'b1;
            StRsend: begin
                tx_valid = 1'b1;
                tx_data  = word_q[{cnt_q, 3'b000} +: 8];
            end
            StResp: begin
                tx_valid = 1'b1;
                tx_data  = resp_q;
            end
            default: ;
        endcase
    end

endmodule
